// File: rtl/maxpool_top.sv
// 2x2 / stride-2 signed max-pooling stage: reads a matrix x matrix map from pixel RAM
// and writes the (matrix/2)^2 pooled map back to it, one window at a time.
module maxpool_top #(
    parameter int unsigned SIZE_1           = 16,
    parameter int unsigned SIZE_address_pix = 12,
    parameter int unsigned RD_LAT           = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               maxp_en,
    input  logic [4:0]                         matrix,
    input  logic [SIZE_address_pix-1:0]        memstartp,
    input  logic [SIZE_address_pix-1:0]        memstartzap,
    output logic [SIZE_address_pix-1:0]        read_addressp,
    output logic                               re,
    input  logic signed [SIZE_1-1:0]           qp,
    output logic [SIZE_address_pix-1:0]        write_addressp,
    output logic                               we,
    output logic signed [SIZE_1-1:0]           dp,
    output logic                               STOP
);

    localparam int unsigned W  = SIZE_1;
    localparam int unsigned AW = SIZE_address_pix;
    localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t              state;
    logic [3:0]          r;
    logic [3:0]          c;
    logic [1:0]          k;
    logic [1:0]          nret;
    logic [RD_LAT-1:0]   vpipe;
    logic signed [W-1:0] mx;

    logic [3:0]          out_c;
    logic                last_col_c;
    logic                last_win_c;
    logic [3:0]          c_nxt_c;
    logic [3:0]          r_nxt_c;
    logic [AW-1:0]       base_c;
    logic [AW-1:0]       base_nxt_c;
    logic [AW-1:0]       off_c;
    logic [AW-1:0]       zap_c;
    logic                ret_c;

    // Window bookkeeping and address arithmetic (all modulo 2^AW).
    always_comb begin
        out_c      = matrix[4:1];
        last_col_c = (c == out_c - 4'd1);
        last_win_c = last_col_c && (r == out_c - 4'd1);
        c_nxt_c    = last_col_c ? 4'd0 : c + 4'd1;
        r_nxt_c    = last_col_c ? r + 4'd1 : r;
        base_c     = memstartp + AW'({r, 1'b0}) * AW'(matrix) + AW'({c, 1'b0});
        base_nxt_c = memstartp + AW'({r_nxt_c, 1'b0}) * AW'(matrix) + AW'({c_nxt_c, 1'b0});
        case (k)
            2'd0:    off_c = AW'(1'b1);
            2'd1:    off_c = AW'(matrix);
            default: off_c = AW'(matrix) + AW'(1'b1);
        endcase
        zap_c      = memstartzap + AW'(r) * AW'(out_c) + AW'(c);
        ret_c      = vpipe[RD_LAT-1];
    end

    // Tracks which cycles carry returned read data; flushed whenever the pass is abandoned.
    generate
        if (RD_LAT == 1) begin : g_vpipe_1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vpipe <= '0;
                end else if (!maxp_en) begin
                    vpipe <= '0;
                end else begin
                    vpipe <= re;
                end
            end
        end else begin : g_vpipe_n
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vpipe <= '0;
                end else if (!maxp_en) begin
                    vpipe <= '0;
                end else begin
                    vpipe <= {vpipe[RD_LAT-2:0], re};
                end
            end
        end
    endgenerate

    // Control FSM with registered RAM-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            r              <= '0;
            c              <= '0;
            k              <= '0;
            nret           <= '0;
            mx             <= MOST_NEG;
            re             <= 1'b0;
            we             <= 1'b0;
            STOP           <= 1'b0;
            read_addressp  <= '0;
            write_addressp <= '0;
            dp             <= '0;
        end else if (!maxp_en) begin
            state <= S_IDLE;
            r     <= '0;
            c     <= '0;
            k     <= '0;
            nret  <= '0;
            mx    <= MOST_NEG;
            re    <= 1'b0;
            we    <= 1'b0;
            STOP  <= 1'b0;
        end else begin
            we <= 1'b0;
            if (ret_c) begin
                if (qp > mx) begin
                    mx <= qp;
                end
                nret <= nret + 2'd1;
            end
            case (state)
                S_IDLE: begin
                    r    <= '0;
                    c    <= '0;
                    k    <= '0;
                    nret <= '0;
                    mx   <= MOST_NEG;
                    if (out_c == 4'd0) begin
                        state <= S_DONE;
                    end else begin
                        state         <= S_RD;
                        re            <= 1'b1;
                        read_addressp <= memstartp;
                    end
                end
                S_RD: begin
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        re    <= 1'b0;
                        state <= S_WAIT;
                    end else begin
                        read_addressp <= base_c + off_c;
                    end
                end
                S_WAIT: begin
                    if (ret_c && nret == 2'd3) begin
                        state <= S_WR;
                    end
                end
                S_WR: begin
                    we             <= 1'b1;
                    dp             <= mx;
                    write_addressp <= zap_c;
                    mx             <= MOST_NEG;
                    nret           <= '0;
                    c              <= c_nxt_c;
                    r              <= r_nxt_c;
                    if (last_win_c) begin
                        state <= S_DONE;
                    end else begin
                        state         <= S_RD;
                        re            <= 1'b1;
                        read_addressp <= base_nxt_c;
                    end
                end
                S_DONE: begin
                    re   <= 1'b0;
                    STOP <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_top.sv
// Directed bench for maxpool_top: table of pooling passes plus enable-drop, async reset
// and read-latency variants, checked against hand-computed windows and cycle positions.
module tb_maxpool_top;

    localparam int unsigned W  = 16;
    localparam int unsigned AW = 12;
    localparam int LAT [3] = '{2, 1, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [4:0]           matrix;
    logic [AW-1:0]        mp;
    logic [AW-1:0]        mz;
    logic                 en   [3];
    logic [AW-1:0]        ra   [3];
    logic [AW-1:0]        wa   [3];
    logic                 re   [3];
    logic                 we   [3];
    logic                 stop [3];
    logic signed [W-1:0]  qp   [3];
    logic signed [W-1:0]  dp   [3];

    logic signed [W-1:0]  mem [3][4096];
    logic [AW-1:0]        p0 [2];
    logic [AW-1:0]        p1;
    logic [AW-1:0]        p2 [3];

    maxpool_top #(.SIZE_1(W), .SIZE_address_pix(AW), .RD_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .maxp_en(en[0]), .matrix(matrix),
        .memstartp(mp), .memstartzap(mz), .read_addressp(ra[0]), .re(re[0]),
        .qp(qp[0]), .write_addressp(wa[0]), .we(we[0]), .dp(dp[0]), .STOP(stop[0]));

    maxpool_top #(.SIZE_1(W), .SIZE_address_pix(AW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .maxp_en(en[1]), .matrix(matrix),
        .memstartp(mp), .memstartzap(mz), .read_addressp(ra[1]), .re(re[1]),
        .qp(qp[1]), .write_addressp(wa[1]), .we(we[1]), .dp(dp[1]), .STOP(stop[1]));

    maxpool_top #(.SIZE_1(W), .SIZE_address_pix(AW), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .maxp_en(en[2]), .matrix(matrix),
        .memstartp(mp), .memstartzap(mz), .read_addressp(ra[2]), .re(re[2]),
        .qp(qp[2]), .write_addressp(wa[2]), .we(we[2]), .dp(dp[2]), .STOP(stop[2]));

    // Pixel RAM read ports with 2, 1 and 3 cycles of latency.
    always @(posedge clk) begin
        p0[0] <= ra[0];
        p0[1] <= p0[0];
        p1    <= ra[1];
        p2[0] <= ra[2];
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign qp[0] = mem[0][p0[1]];
    assign qp[1] = mem[1][p1];
    assign qp[2] = mem[2][p2[2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int dut;
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t wq[$];
    int  stop_cyc [3];
    int  rd_cnt;
    int  bad_rd;
    int  n_chk  = 0;
    int  n_fail = 0;

    // Write/STOP/read monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [AW-1:0] rel;
        int half;
        for (int d = 0; d < 3; d++) begin
            if (we[d]) wq.push_back('{d, int'(wa[d]), int'(dp[d]), cyc});
            if (stop[d] && stop_cyc[d] < 0) stop_cyc[d] = cyc;
        end
        if (re[0] && matrix >= 5'd2) begin
            rd_cnt++;
            rel  = ra[0] - mp;
            half = 2 * (int'(matrix) / 2);
            if (int'(rel) / int'(matrix) >= half || int'(rel) % int'(matrix) >= half) bad_rd++;
        end
    end

    typedef struct {
        string name;
        int    m;
        int    mpv;
        int    mzv;
        int    pat;
        int    nw;
        int    ed [4];
    } vec_t;

    vec_t tv [6];
    int neg_map [16] = '{-8, -3, -9, -12, -5, -7, -16, -10, -1, -2, -4, -6, -11, -13, -14, -15};
    int inc_exp [4]  = '{5, 7, 13, 15};

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_vec(input int i, input string nm, input int m, input int mpv, input int mzv,
                           input int pat, input int nw, input int e0, input int e1, input int e2,
                           input int e3);
        tv[i].name = nm;
        tv[i].m    = m;
        tv[i].mpv  = mpv;
        tv[i].mzv  = mzv;
        tv[i].pat  = pat;
        tv[i].nw   = nw;
        tv[i].ed[0] = e0;
        tv[i].ed[1] = e1;
        tv[i].ed[2] = e2;
        tv[i].ed[3] = e3;
    endtask

    task automatic clear_mon();
        wq.delete();
        for (int d = 0; d < 3; d++) stop_cyc[d] = -1;
        rd_cnt = 0;
        bad_rd = 0;
    endtask

    task automatic fill(input int pat, input int m, input int base);
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < m * m; i++) begin
                mem[d][(base + i) % 4096] = W'((pat == 1) ? neg_map[i] : i);
            end
        end
    endtask

    task automatic setup(input int m, input int mpv, input int mzv);
        matrix = 5'(m);
        mp     = AW'(mpv);
        mz     = AW'(mzv);
    endtask

    task automatic start(input int d, output int t0);
        @(negedge clk);
        #1;
        en[d] = 1'b1;
        t0    = cyc + 1;
    endtask

    task automatic wait_stop(input string nm, input int d, input int budget);
        int n;
        n = 0;
        while (stop_cyc[d] < 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, "_stop_seen"}, int'(stop_cyc[d] >= 0), 1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_pass(input string nm, input int d, input int nw, input int mzv,
                              input int ed [4], input int t0);
        int n;
        int per;
        n   = 0;
        per = 5 + LAT[d];
        foreach (wq[i]) begin
            if (wq[i].dut == d) begin
                if (n < 4) begin
                    chk({nm, "_data"}, wq[i].data, ed[n]);
                    chk({nm, "_waddr"}, wq[i].addr, (mzv + n) % 4096);
                    chk({nm, "_wcyc"}, wq[i].cyc - t0, per * (n + 1));
                end
                n++;
            end
        end
        chk({nm, "_nwrites"}, n, nw);
        chk({nm, "_stop_cyc"}, stop_cyc[d] - t0, nw * per + 1);
        if (d == 0) begin
            chk({nm, "_nreads"}, rd_cnt, 4 * nw);
            chk({nm, "_bad_reads"}, bad_rd, 0);
        end
    endtask

    task automatic finish_pass(input string nm, input int d);
        @(negedge clk);
        #1;
        en[d] = 1'b0;
        @(negedge clk);
        #1;
        chk({nm, "_stop_clear"}, int'(stop[d]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nwr;

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) en[d] = 1'b0;
        setup(4, 0, 0);
        clear_mon();

        set_vec(0, "inc4",  4, 100,  500, 0, 4,  5,  7, 13, 15);
        set_vec(1, "neg4",  4, 200,  600, 1, 4, -3, -9, -1, -4);
        set_vec(2, "odd5",  5, 300,  700, 0, 4,  6,  8, 16, 18);
        set_vec(3, "wrap4", 4, 4090, 2000, 0, 4, 5,  7, 13, 15);
        set_vec(4, "m1",    1, 100,  800, 0, 0,  0,  0,  0,  0);
        set_vec(5, "m3",    3, 100,  900, 0, 1,  4,  0,  0,  0);

        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_re", int'(re[d]), 0);
            chk("rst_we", int'(we[d]), 0);
            chk("rst_stop", int'(stop[d]), 0);
        end
        chk("rst_raddr", int'(ra[0]), 0);
        chk("rst_waddr", int'(wa[0]), 0);
        chk("rst_dp", int'(dp[0]), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            setup(tv[i].m, tv[i].mpv, tv[i].mzv);
            fill(tv[i].pat, tv[i].m, tv[i].mpv);
            clear_mon();
            start(0, t0);
            wait_stop(tv[i].name, 0, 200);
            check_pass(tv[i].name, 0, tv[i].nw, tv[i].mzv, tv[i].ed, t0);
            finish_pass(tv[i].name, 0);
        end

        // Enable dropped while window 1 waits for data; then a clean restart.
        setup(4, 100, 500);
        fill(0, 4, 100);
        clear_mon();
        start(0, t0);
        wait_cyc(t0 + 11);
        chk("drop_in_wait_re", int'(re[0]), 0);
        en[0] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
        end
        nwr = 0;
        foreach (wq[i]) if (wq[i].dut == 0) nwr++;
        chk("drop_nwrites", nwr, 1);
        chk("drop_stop", int'(stop[0]), 0);
        chk("drop_re", int'(re[0]), 0);
        clear_mon();
        start(0, t0);
        wait_stop("restart", 0, 200);
        check_pass("restart", 0, 4, 500, inc_exp, t0);
        finish_pass("restart", 0);

        // Asynchronous reset in the middle of window 1's reads.
        clear_mon();
        start(0, t0);
        wait_cyc(t0 + 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_re", int'(re[0]), 0);
        chk("arst_we", int'(we[0]), 0);
        chk("arst_stop", int'(stop[0]), 0);
        chk("arst_raddr", int'(ra[0]), 0);
        chk("arst_waddr", int'(wa[0]), 0);
        chk("arst_dp", int'(dp[0]), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
        t0 = cyc + 1;
        wait_stop("post_rst", 0, 200);
        check_pass("post_rst", 0, 4, 500, inc_exp, t0);
        finish_pass("post_rst", 0);

        // Same map through the RD_LAT=1 and RD_LAT=3 builds, started together.
        fill(0, 4, 100);
        clear_mon();
        @(negedge clk);
        #1;
        en[1] = 1'b1;
        en[2] = 1'b1;
        t0 = cyc + 1;
        wait_stop("lat3", 2, 200);
        chk("lat1_stop_seen", int'(stop_cyc[1] >= 0), 1);
        check_pass("lat1", 1, 4, 500, inc_exp, t0);
        check_pass("lat3", 2, 4, 500, inc_exp, t0);
        finish_pass("lat1", 1);
        finish_pass("lat3", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
